imem_loader: RTL and testbench

Boot-time program loader that is the writer side of the instruction memory port. It receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words. Each word is written sequentially into the instruction memory's write port. The loader holds the processor in reset (`cpu_hold`) until a complete frame with a good checksum has been written, so the processor's first instruction fetch sees a fully loaded program.

---
 rtl/imem_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory loader. Accepts a framed byte
//               stream over valid/ready, assembles big-endian 32-bit words,
//               writes them to sequential word addresses and holds the CPU in
//               reset until a complete frame with a matching XOR checksum has
//               been written.
//
//               Frame: HI (N[12:8], top 3 bits zero) | LO (N[7:0]) |
//                      N x 4 data bytes (MSB first) | XOR of all prior bytes
//
// Ports       : clock       - single clock, rising edge
//               reset       - asynchronous, active-low
//               in_valid    - in_byte carries a stream byte
//               in_byte     - stream byte
//               in_ready    - loader will accept a byte this cycle
//               start       - one-cycle pulse, rearms after DONE / ERROR
//               wr_en       - instruction memory write strobe (1 cycle)
//               wr_address  - word address of the write
//               wr_data     - instruction word of the write
//               cpu_hold    - 1 keeps the processor in reset
//               done        - frame loaded and verified
//               error       - frame rejected (sticky until start / reset)
//               word_count  - N from the frame header
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_WORDS  = 4096
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   input  logic                  start,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_address,
   output logic [31:0]           wr_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [12:0]           word_count
);

   // -------------------------------------------------------------------------
   // State encoding
   // -------------------------------------------------------------------------
   localparam logic [2:0] c_hdr_hi = 3'd0;
   localparam logic [2:0] c_hdr_lo = 3'd1;
   localparam logic [2:0] c_data   = 3'd2;
   localparam logic [2:0] c_check  = 3'd3;
   localparam logic [2:0] c_done   = 3'd4;
   localparam logic [2:0] c_error  = 3'd5;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [2:0]            state_q,      state_d;
   logic [7:0]            hi_q,         hi_d;          // captured HI header byte
   logic [7:0]            csum_q,       csum_d;        // running XOR of frame bytes
   logic [1:0]            byte_pos_q,   byte_pos_d;    // byte index within a word
   logic [23:0]           word_buf_q,   word_buf_d;    // first three bytes of a word
   logic [12:0]           idx_q,        idx_d;         // next word index to write
   logic [12:0]           word_count_q, word_count_d;
   logic                  in_ready_q,   in_ready_d;
   logic                  wr_en_q,      wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
   logic [31:0]           wr_data_q,    wr_data_d;
   logic                  cpu_hold_q,   cpu_hold_d;
   logic                  done_q,       done_d;
   logic                  error_q,      error_d;

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic        w_accept;
   logic [12:0] w_hdr_n;
   logic        w_hdr_bad;
   logic        w_last_word;

   // A byte transfers when offered while the registered ready is high; the
   // registered ready always reflects the current state (except the single
   // cycle after reset, where it is intentionally still low).
   assign w_accept    = in_valid && in_ready_q;
   assign w_hdr_n     = {hi_q[4:0], in_byte};
   assign w_hdr_bad   = (hi_q[7:5] != 3'b000) || (32'(w_hdr_n) > 32'(MAX_WORDS));
   assign w_last_word = (idx_q == (word_count_q - 13'd1));

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      csum_d       = csum_q;
      byte_pos_d   = byte_pos_q;
      word_buf_d   = word_buf_q;
      idx_d        = idx_q;
      word_count_d = word_count_q;
      wr_en_d      = 1'b0;
      wr_address_d = wr_address_q;
      wr_data_d    = wr_data_q;

      case (state_q)
         c_hdr_hi: begin
            if (w_accept) begin
               hi_d    = in_byte;
               csum_d  = csum_q ^ in_byte;
               state_d = c_hdr_lo;
            end
         end

         c_hdr_lo: begin
            if (w_accept) begin
               csum_d       = csum_q ^ in_byte;
               word_count_d = w_hdr_n;
               byte_pos_d   = 2'd0;
               idx_d        = 13'd0;
               if (w_hdr_bad) begin
                  state_d = c_error;
               end else if (w_hdr_n == 13'd0) begin
                  state_d = c_check;
               end else begin
                  state_d = c_data;
               end
            end
         end

         c_data: begin
            if (w_accept) begin
               csum_d = csum_q ^ in_byte;
               if (byte_pos_q == 2'd3) begin
                  // Fourth byte completes the word: write it out directly
                  // from the buffer plus the incoming byte.
                  wr_en_d      = 1'b1;
                  wr_data_d    = {word_buf_q, in_byte};
                  wr_address_d = idx_q[ADDR_WIDTH-1:0];
                  idx_d        = idx_q + 13'd1;
                  byte_pos_d   = 2'd0;
                  if (w_last_word) begin
                     state_d = c_check;
                  end
               end else begin
                  word_buf_d = {word_buf_q[15:0], in_byte};
                  byte_pos_d = byte_pos_q + 2'd1;
               end
            end
         end

         c_check: begin
            if (w_accept) begin
               state_d = (csum_q == in_byte) ? c_done : c_error;
            end
         end

         c_done, c_error: begin
            if (start) begin
               state_d      = c_hdr_hi;
               csum_d       = 8'h00;
               idx_d        = 13'd0;
               byte_pos_d   = 2'd0;
               word_buf_d   = 24'h000000;
               word_count_d = 13'd0;
            end
         end

         default: begin
            state_d = c_hdr_hi;
         end
      endcase

      // Status outputs are registered from the state being left/entered so
      // that a start pulse clears done/error on the same edge it rearms,
      // while entry into DONE/ERROR shows up one edge after the final byte.
      in_ready_d = (state_d == c_hdr_hi) || (state_d == c_hdr_lo) ||
                   (state_d == c_data)   || (state_d == c_check);
      done_d     = (state_q == c_done)  && (state_d == c_done);
      error_d    = (state_q == c_error) && (state_d == c_error);
      cpu_hold_d = !done_d;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= c_hdr_hi;
         hi_q         <= 8'h00;
         csum_q       <= 8'h00;
         byte_pos_q   <= 2'd0;
         word_buf_q   <= 24'h000000;
         idx_q        <= 13'd0;
         word_count_q <= 13'd0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_address_q <= '0;
         wr_data_q    <= 32'h0000_0000;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         csum_q       <= csum_d;
         byte_pos_q   <= byte_pos_d;
         word_buf_q   <= word_buf_d;
         idx_q        <= idx_d;
         word_count_q <= word_count_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_address_q <= wr_address_d;
         wr_data_q    <= wr_data_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Frames are built as byte
//               queues; a frame-level model derives N, the expected writes,
//               the accepted byte count and the verdict. A monitor process
//               checks every write strobe against the expected write queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int AW   = 12;
   localparam int MAXW = 4096;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_byte = 8'h00;
   logic          start = 1'b0;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_address;
   logic [31:0]   wr_data;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [12:0]   word_count;

   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;
   bit  active      = 1'b0;
   bit  gapless     = 1'b0;
   wr_t exp_q[$];
   wr_t log_q[$];

   imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .start      (start),
      .wr_en      (wr_en),
      .wr_address (wr_address),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Frame-level reference: what the loader must do with this byte sequence.
   task automatic model(input logic [7:0] fr[$], output int acc, output bit ok,
                        output logic [12:0] n, output logic [7:0] xs);
      n  = {fr[0][4:0], fr[1]};
      xs = 8'h00;
      if (fr[0][7:5] != 3'b000 || int'(n) > MAXW) begin
         acc = 2;
         ok  = 1'b0;
         return;
      end
      for (int i = 0; i < 2 + 4 * int'(n); i++) xs ^= fr[i];
      acc = 3 + 4 * int'(n);
      ok  = (xs == fr[acc-1]);
   endtask

   // Queue the writes whose fourth byte lies within the first 'count' bytes.
   task automatic push_writes(input logic [7:0] fr[$], input int count);
      int acc; bit ok; logic [12:0] n; logic [7:0] xs;
      wr_t w;
      model(fr, acc, ok, n, xs);
      if (acc == 2) return;
      for (int i = 0; i < int'(n); i++) begin
         if (2 + 4 * i + 3 < count) begin
            w.a = AW'(i);
            w.d = {fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]};
            exp_q.push_back(w);
         end
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   initial begin : monitor
      int  last_wr;
      wr_t w;
      last_wr = -1;
      forever begin
         @(negedge clock);
         if (!active) last_wr = -1;
         if (!reset) begin
            check("wr_en_in_reset", {63'd0, wr_en}, 64'd0);
         end else begin
            if (wr_en) begin
               log_q.push_back({wr_address, wr_data});
               if (exp_q.size() == 0) begin
                  check("unexpected_wr", 64'd1, 64'd0);
               end else begin
                  w = exp_q.pop_front();
                  check("wr_address", 64'(wr_address), 64'(w.a));
                  check("wr_data", 64'(wr_data), 64'(w.d));
                  if (gapless && last_wr >= 0) check("wr_spacing", 64'(cyc - last_wr), 64'd4);
                  last_wr = cyc;
               end
            end
            if (active) check("hold_during_load", {61'd0, cpu_hold, done, error}, 64'b100);
         end
      end
   end

   // gap < 0: random 0..3 idle cycles before each byte; otherwise fixed.
   task automatic send(input logic [7:0] fr[$], input int count, input int gap);
      int tries;
      int g;
      for (int i = 0; i < count; i++) begin
         g = (gap < 0) ? $urandom_range(0, 3) : gap;
         repeat (g) begin
            @(negedge clock);
            in_valid = 1'b0;
         end
         tries = 0;
         do begin
            @(negedge clock);
            in_valid = 1'b1;
            in_byte  = fr[i];
            tries++;
         end while (!in_ready && tries < 50);
         if (!in_ready) begin
            check("in_ready_stuck", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},   64'(in_ready),   64'd0);
      check({tag, "_wr_en"},      64'(wr_en),      64'd0);
      check({tag, "_wr_address"}, 64'(wr_address), 64'd0);
      check({tag, "_wr_data"},    64'(wr_data),    64'd0);
      check({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
      check({tag, "_done"},       64'(done),       64'd0);
      check({tag, "_error"},      64'(error),      64'd0);
      check({tag, "_word_count"}, 64'(word_count), 64'd0);
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("rearm_in_ready", 64'(in_ready),   64'd1);
      check("rearm_done",     64'(done),       64'd0);
      check("rearm_error",    64'(error),      64'd0);
      check("rearm_cpu_hold", 64'(cpu_hold),   64'd1);
      check("rearm_count",    64'(word_count), 64'd0);
   endtask

   task automatic run_frame(input logic [7:0] fr[$], input int gap);
      int acc; bit ok; logic [12:0] n; logic [7:0] xs;
      model(fr, acc, ok, n, xs);
      push_writes(fr, acc);
      gapless = (gap == 0);
      active  = 1'b1;
      send(fr, acc, gap);
      @(negedge clock);
      in_valid = 1'b0;
      active   = 1'b0;
      check("ready_after_last", 64'(in_ready), 64'd0);
      check("status_early",     {62'd0, done, error}, 64'd0);
      @(negedge clock);
      check("done",          64'(done),       64'(ok));
      check("error",         64'(error),      64'(!ok));
      check("cpu_hold",      64'(cpu_hold),   64'(!ok));
      check("word_count",    64'(word_count), 64'(n));
      check("writes_missed", 64'(exp_q.size()), 64'd0);
      // Bytes offered after the frame must not be consumed.
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      repeat (3) @(negedge clock);
      in_valid = 1'b0;
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_status",   {62'd0, done, error}, {62'd0, ok, !ok});
   endtask

   initial begin : main
      logic [7:0] basic[$];
      logic [7:0] fr[$];
      int acc; bit ok; logic [12:0] n; logic [7:0] xs;
      int nw;

      // XOR of 00 02 12 34 56 78 9A BC DE F0 is 0x02.
      basic = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};

      // Pin the model with hand-computed values.
      model(basic, acc, ok, n, xs);
      check("model_xsum", 64'(xs), 64'h02);
      check("model_n",    64'(n),  64'd2);
      check("model_acc",  64'(acc), 64'd11);
      fr = '{8'h13, 8'h88};
      model(fr, acc, ok, n, xs);
      check("model_big_n", {51'd0, n}, 64'd5000);
      check("model_big_acc", 64'(acc), 64'd2);

      // Reset values, then ready one edge after release.
      repeat (3) @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b1;
      #1 check("ready_at_release", 64'(in_ready), 64'd0);
      @(negedge clock);
      check("ready_after_release", 64'(in_ready), 64'd1);

      // Basic gapless load with literal write checks.
      log_q.delete();
      run_frame(basic, 0);
      check("log_len", 64'(log_q.size()), 64'd2);
      if (log_q.size() == 2) begin
         check("log_wr0", 64'(log_q[0]), 64'({12'd0, 32'h12345678}));
         check("log_wr1", 64'(log_q[1]), 64'({12'd1, 32'h9ABCDEF0}));
      end
      pulse_start();

      // Same frame with 3 idle cycles before each byte.
      log_q.delete();
      run_frame(basic, 3);
      check("stall_log_len", 64'(log_q.size()), 64'd2);
      pulse_start();

      // Bad checksum.
      fr = basic;
      fr[10] = 8'h0B;
      run_frame(fr, 0);
      pulse_start();

      // Empty frame, then oversize header.
      fr = '{8'h00, 8'h00, 8'h00};
      run_frame(fr, 0);
      pulse_start();
      fr = '{8'h13, 8'h88};
      run_frame(fr, 0);
      pulse_start();

      // Reset after two bytes of word 1: only word 0 is written.
      push_writes(basic, 8);
      gapless = 1'b1;
      send(basic, 8, 0);
      @(negedge clock);
      in_valid = 1'b0;
      reset    = 1'b0;
      #1 check_reset_vals("midrst");
      repeat (2) @(negedge clock);
      check("midrst_writes", 64'(exp_q.size()), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_ready", 64'(in_ready), 64'd1);
      log_q.delete();
      run_frame(basic, 0);
      if (log_q.size() > 0) check("midrst_addr0", 64'(log_q[0].a), 64'd0);
      pulse_start();

      // Randomized frames.
      for (int f = 0; f < 30; f++) begin
         fr.delete();
         if ($urandom_range(0, 7) == 0) begin
            fr.push_back(8'($urandom_range(17, 255)));
            fr.push_back(8'($urandom));
         end else begin
            nw = $urandom_range(0, 6);
            fr.push_back(8'h00);
            fr.push_back(8'(nw));
            for (int i = 0; i < 4 * nw; i++) fr.push_back(8'($urandom));
            xs = 8'h00;
            for (int i = 0; i < fr.size(); i++) xs ^= fr[i];
            if ($urandom_range(0, 3) == 0) xs ^= 8'($urandom_range(1, 255));
            fr.push_back(xs);
         end
         run_frame(fr, ($urandom_range(0, 1) == 0) ? 0 : -1);
         pulse_start();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
